// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
// Holds the control state encoding, the default operand width and the counter sizing.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_4bit_if.sv
// Operand/result bundle of the bit-serial adder.
// The master side issues start and operands; the slave side returns status and the result.
interface serial_adder_4bit_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             V;

  modport master (output start, a, b, c_in, input busy, done, s, c_out, V);
  modport slave  (input start, a, b, c_in, output busy, done, s, c_out, V);
endinterface

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell; the subtractor reuses it with the subtrahend inverted.
module full_adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first.
// Result, carry-out and signed overflow update only on the completion edge.
module serial_adder_4bit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_adder_4bit_if.slave bus
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_c_out;
  logic               r_v;
  logic               w_sum_bit;
  logic               w_carry;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic               w_busy;
  logic               w_done;

  full_adder_1bit u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum_bit),
    .o_cout (w_carry)
  );

  assign w_accept  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH steps bit 0 lands in place.
  assign w_sum_nxt = WIDTH'({w_sum_bit, r_sum_sh} >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = bus.start ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_SHIFT: w_busy = 1'b1;
      ST_DONE:  w_done = 1'b1;
      default:  ;
    endcase
  end

  // Working shift registers, carry and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_sum_sh <= '0;
      r_carry  <= bus.c_in;
      r_cnt    <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_nxt;
      r_carry  <= w_carry;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Visible result only moves on the MSB step, so partial sums never leak out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_v     <= 1'b0;
    end else if (w_last) begin
      r_s     <= w_sum_nxt;
      r_c_out <= w_carry;
      r_v     <= r_carry ^ w_carry;
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.s     = r_s;
  assign bus.c_out = r_c_out;
  assign bus.V     = r_v;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for the bit-serial adder: directed cases with literal results,
// a reset-mid-operation case and a randomized full operand sweep against an arithmetic model.
module tb_serial_adder_4bit;
  localparam int unsigned W = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clk = ~clk;

  serial_adder_4bit_if #(.WIDTH(W)) bus ();

  serial_adder_4bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {V, c_out, s} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    int ua, ub, us, sa, sb, ss, lim;
    logic v;
    ua  = int'(a);
    ub  = int'(b);
    us  = ua + ub + int'(cin);
    lim = 1 << (W - 1);
    sa  = a[W-1] ? ua - (1 << W) : ua;
    sb  = b[W-1] ? ub - (1 << W) : ub;
    ss  = sa + sb + int'(cin);
    v   = (ss > lim - 1) || (ss < -lim);
    return {v, (W+1)'(us)};
  endfunction

  // Transaction-level model: an accepted add keeps the block busy W cycles, then done for one.
  int             m_rem  = 0;
  logic           m_done = 1'b0;
  logic [W+1:0]   m_out  = '0;
  logic [W+1:0]   m_pend = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_out  = '0;
      m_pend = '0;
    end else begin
      m_done = (m_rem == 1);
      if (m_rem == 1) m_out = m_pend;
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (bus.start) begin
        m_rem  = W;
        m_pend = ref_add(bus.a, bus.b, bus.c_in);
      end
    end
  end

  always @(negedge clk) begin
    check("cycle", 32'({bus.busy, bus.done, bus.V, bus.c_out, bus.s}),
          32'({(m_rem > 0), m_done, m_out}));
  end

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = cin;
  endtask

  task automatic drive_junk(input logic st);
    drive(st, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  // Start accepted on the edge after driving; optionally keep start high for extra cycles.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold);
    @(posedge clk); #2;
    drive(1'b1, a, b, cin);
    @(posedge clk); #2;
    repeat (hold) begin
      drive_junk(1'b1);
      @(posedge clk); #2;
    end
    drive_junk(1'b0);
  endtask

  task automatic expect_done(input string name, input logic [W-1:0] es, input logic ec,
                             input logic ev, input int exp_busy);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nb++;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
      check({name, "_s"}, 32'(bus.s), 32'(es));
      check({name, "_c_out"}, 32'(bus.c_out), 32'(ec));
      check({name, "_V"}, 32'(bus.V), 32'(ev));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0]   v;
    logic [W+1:0] exp;
    logic [W-1:0] prev_s;
    int           nd;
    int           holdbad;
    bit           seen;

    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("reset_state", 32'({bus.busy, bus.done, bus.V, bus.c_out, bus.s}), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    start_op(4'b1111, 4'b0001, 1'b0, 0);
    expect_done("wrap_ones", 4'b0000, 1'b1, 1'b0, 4);
    start_op(4'b0111, 4'b0001, 1'b0, 0);
    expect_done("pos_ovf", 4'b1000, 1'b0, 1'b1, 4);
    start_op(4'b1000, 4'b1000, 1'b0, 0);
    expect_done("neg_ovf", 4'b0000, 1'b1, 1'b1, 4);

    // Start held high through SHIFT must not restart the add.
    start_op(4'b0000, 4'b0000, 1'b1, 3);
    expect_done("cin_only", 4'b0001, 1'b0, 1'b0, 1);
    check("single_done_pulse_next", 32'(bus.done), 32'd1);

    // Back-to-back start issued in the DONE cycle.
    drive(1'b1, 4'b0011, 4'b0010, 1'b0);
    @(posedge clk); #2;
    drive_junk(1'b0);
    expect_done("back_to_back", 4'b0101, 1'b0, 1'b0, 4);

    // Asynchronous reset in the middle of an add.
    start_op(4'b1111, 4'b1111, 1'b0, 0);
    @(posedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("reset_async_outputs", 32'({bus.busy, bus.done, bus.V, bus.c_out, bus.s}), 32'd0);
    @(posedge clk); #2;
    check("reset_held_outputs", 32'({bus.busy, bus.done, bus.V, bus.c_out, bus.s}), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    check("no_activity_after_reset", 32'(nd), 32'd0);

    // Full operand sweep with junk inputs while busy and random back-to-back starts.
    prev_s = bus.s;
    for (int k = 0; k < 512; k++) begin
      v   = 9'(k);
      exp = ref_add(v[3:0], v[7:4], v[8]);
      drive(1'b1, v[3:0], v[7:4], v[8]);
      @(posedge clk); #2;
      drive_junk(1'b0);
      seen    = 1'b0;
      holdbad = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.done) seen = 1'b1;
        else begin
          if (bus.s !== prev_s) holdbad++;
          drive_junk(1'($urandom));
        end
      end
      check("sweep_done_seen", 32'(seen), 32'd1);
      check("sweep_s_hold", 32'(holdbad), 32'd0);
      check("sweep_result", 32'({bus.V, bus.c_out, bus.s}), 32'(exp));
      prev_s = bus.s;
      drive_junk(1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
